// File: rtl/hazard_ctrl_if.sv
// Hazard controller port bundle: D/E/M/W register
// fields and md controls in, stall/forward selects out.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int T_W    = 2,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] rs_D;
  logic [REG_AW-1:0] rt_D;
  logic [T_W-1:0]    tuse_rs_D;
  logic [T_W-1:0]    tuse_rt_D;
  logic              md_use_D;
  logic [REG_AW-1:0] rs_E;
  logic [REG_AW-1:0] rt_E;
  logic [REG_AW-1:0] a3_E;
  logic [REG_AW-1:0] a3_M;
  logic [REG_AW-1:0] a3_W;
  logic [T_W-1:0]    tnew_E;
  logic [T_W-1:0]    tnew_M;
  logic              md_start_E;
  logic              md_div_E;
  logic              md_cancel;
  logic              stall;
  logic              bubble_E;
  logic [1:0]        fwd_rs_D;
  logic [1:0]        fwd_rt_D;
  logic [1:0]        fwd_rs_E;
  logic [1:0]        fwd_rt_E;
  logic              md_busy;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D,
    output md_use_D, rs_E, rt_E,
    output a3_E, a3_M, a3_W, tnew_E, tnew_M,
    output md_start_E, md_div_E, md_cancel,
    input  stall, bubble_E,
    input  fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E,
    input  md_busy, stall_cnt
  );

  modport slave (
    input  rs_D, rt_D, tuse_rs_D, tuse_rt_D,
    input  md_use_D, rs_E, rt_E,
    input  a3_E, a3_M, a3_W, tnew_E, tnew_M,
    input  md_start_E, md_div_E, md_cancel,
    output stall, bubble_E,
    output fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E,
    output md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Tuse/Tnew hazard controller for the 5-stage pipeline:
// stall/bubble, D/E forwarding, md busy tracking, stall counter.
module hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int T_W        = 2,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W      = 32
) (
  input logic         clk,
  input logic         reset,
  hazard_ctrl_if.slave hz
);

  localparam int MD_W = $clog2(DIV_CYCLES + 1);
  localparam logic [T_W-1:0] T_NONE = '1;

  typedef logic [REG_AW-1:0] reg_t;
  typedef logic [T_W-1:0]    t_t;

  function automatic logic data_hz(
    input reg_t s,   input t_t tu,
    input reg_t a3e, input t_t tne,
    input reg_t a3m, input t_t tnm
  );
    logic hit_e;
    logic hit_m;
    hit_e = (s == a3e) && (tne > tu);
    hit_m = (s == a3m) && (tnm > tu);
    return (s != '0) && (tu != T_NONE)
           && (hit_e || hit_m);
  endfunction

  function automatic logic [1:0] fwd_d(
    input reg_t s,
    input reg_t a3e, input t_t tne,
    input reg_t a3m, input t_t tnm,
    input reg_t a3w
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (s == '0)
      sel = 2'd0;
    else if (s == a3e && tne == '0)
      sel = 2'd1;
    else if (s == a3m && tnm == '0)
      sel = 2'd2;
    else if (s == a3w)
      sel = 2'd3;
    return sel;
  endfunction

  // E stage never selects code 1: an E-to-E path does not exist.
  function automatic logic [1:0] fwd_e(
    input reg_t s,
    input reg_t a3m, input t_t tnm,
    input reg_t a3w
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (s == '0)
      sel = 2'd0;
    else if (s == a3m && tnm == '0)
      sel = 2'd2;
    else if (s == a3w)
      sel = 2'd3;
    return sel;
  endfunction

  logic [MD_W-1:0]  md_cnt;
  logic [CNT_W-1:0] cnt_q;
  logic             busy;
  logic             hz_rs;
  logic             hz_rt;
  logic             hz_md;
  logic             stall_w;

  assign busy  = (md_cnt != '0) || hz.md_start_E;

  assign hz_rs = data_hz(hz.rs_D, hz.tuse_rs_D,
                         hz.a3_E, hz.tnew_E,
                         hz.a3_M, hz.tnew_M);
  assign hz_rt = data_hz(hz.rt_D, hz.tuse_rt_D,
                         hz.a3_E, hz.tnew_E,
                         hz.a3_M, hz.tnew_M);
  assign hz_md = hz.md_use_D && busy;

  assign stall_w     = hz_rs || hz_rt || hz_md;
  assign hz.stall    = stall_w;
  assign hz.bubble_E = stall_w;
  assign hz.md_busy  = busy;
  assign hz.stall_cnt = cnt_q;

  assign hz.fwd_rs_D = fwd_d(hz.rs_D,
                             hz.a3_E, hz.tnew_E,
                             hz.a3_M, hz.tnew_M,
                             hz.a3_W);
  assign hz.fwd_rt_D = fwd_d(hz.rt_D,
                             hz.a3_E, hz.tnew_E,
                             hz.a3_M, hz.tnew_M,
                             hz.a3_W);
  assign hz.fwd_rs_E = fwd_e(hz.rs_E,
                             hz.a3_M, hz.tnew_M,
                             hz.a3_W);
  assign hz.fwd_rt_E = fwd_e(hz.rt_E,
                             hz.a3_M, hz.tnew_M,
                             hz.a3_W);

  // Cancel beats a same-cycle start so a flushed md never runs.
  always_ff @(posedge clk) begin
    if (!reset)
      md_cnt <= '0;
    else if (hz.md_cancel)
      md_cnt <= '0;
    else if (hz.md_start_E)
      md_cnt <= hz.md_div_E ? MD_W'(DIV_CYCLES)
                            : MD_W'(MUL_CYCLES);
    else if (md_cnt != '0)
      md_cnt <= md_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset)
      cnt_q <= '0;
    else if (stall_w && cnt_q != '1)
      cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with an expectation queue;
// a second narrow-counter instance covers saturation.
module tb_hazard_ctrl;

  logic clk;
  logic reset;

  hazard_ctrl_if hz ();
  hazard_ctrl_if #(.CNT_W(3)) hz2 ();

  hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  hazard_ctrl #(.CNT_W(3)) dut2 (
    .clk   (clk),
    .reset (reset),
    .hz    (hz2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [42:0] v;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_cnt = '0;

  always @(negedge clk) begin
    if (reset === 1'b1 && hz.md_start_E === 1'b1)
      assert (dut.md_cnt == '0)
      else $error("illegal md restart while busy");
  end

  task automatic idle();
    hz.rs_D = '0;  hz.rt_D = '0;
    hz.tuse_rs_D = '1; hz.tuse_rt_D = '1;
    hz.md_use_D = 1'b0;
    hz.rs_E = '0;  hz.rt_E = '0;
    hz.a3_E = '0;  hz.a3_M = '0; hz.a3_W = '0;
    hz.tnew_E = '0; hz.tnew_M = '0;
    hz.md_start_E = 1'b0;
    hz.md_div_E = 1'b0;
    hz.md_cancel = 1'b0;
  endtask

  task automatic chk(
    input string      tag,
    input logic       st,
    input logic [1:0] f_rs_d,
    input logic [1:0] f_rt_d,
    input logic [1:0] f_rs_e,
    input logic [1:0] f_rt_e,
    input logic       busy
  );
    exp_t e;
    logic [42:0] got;
    e.tag = tag;
    e.v = {st, st, f_rs_d, f_rt_d,
           f_rs_e, f_rt_e, busy, exp_cnt};
    sb.push_back(e);
    @(negedge clk);
    got = {hz.stall, hz.bubble_E,
           hz.fwd_rs_D, hz.fwd_rt_D,
           hz.fwd_rs_E, hz.fwd_rt_E,
           hz.md_busy, hz.stall_cnt};
    e = sb.pop_front();
    checks++;
    assert (got === e.v)
    else begin
      errors++;
      $error("FAIL %s got=%h exp=%h",
             e.tag, got, e.v);
    end
    if (!reset)
      exp_cnt = '0;
    else if (st && exp_cnt != '1)
      exp_cnt = exp_cnt + 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    hz2.rs_D = 5'd8; hz2.rt_D = '0;
    hz2.tuse_rs_D = 2'd1; hz2.tuse_rt_D = '1;
    hz2.md_use_D = 1'b0;
    hz2.rs_E = '0; hz2.rt_E = '0;
    hz2.a3_E = 5'd8; hz2.a3_M = '0; hz2.a3_W = '0;
    hz2.tnew_E = 2'd2; hz2.tnew_M = '0;
    hz2.md_start_E = 1'b0; hz2.md_div_E = 1'b0;
    hz2.md_cancel = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_idle", 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    chk("post_reset", 0, 0, 0, 0, 0, 0);

    hz.a3_E = 5'd8; hz.tnew_E = 2'd2;
    hz.rs_D = 5'd8; hz.tuse_rs_D = 2'd1;
    chk("load_use", 1, 0, 0, 0, 0, 0);
    hz.a3_E = '0; hz.tnew_E = '0;
    hz.a3_M = 5'd8; hz.tnew_M = 2'd1;
    chk("load_use_m", 0, 0, 0, 0, 0, 0);
    idle();
    hz.rs_E = 5'd8; hz.a3_W = 5'd8;
    chk("load_use_w", 0, 0, 0, 3, 0, 0);

    idle();
    hz.a3_E = 5'd9; hz.tnew_E = 2'd1;
    hz.rt_D = 5'd9; hz.tuse_rt_D = 2'd0;
    chk("alu_branch", 1, 0, 0, 0, 0, 0);
    hz.a3_E = '0; hz.tnew_E = '0;
    hz.a3_M = 5'd9; hz.tnew_M = 2'd0;
    chk("alu_branch_m", 0, 0, 2, 0, 0, 0);

    idle();
    hz.tnew_E = 2'd2; hz.tuse_rs_D = 2'd0;
    chk("reg_zero", 0, 0, 0, 0, 0, 0);

    idle();
    hz.rs_D = 5'd5; hz.tuse_rs_D = 2'd0;
    hz.a3_E = 5'd5; hz.a3_M = 5'd5; hz.a3_W = 5'd5;
    chk("prio_e", 0, 1, 0, 0, 0, 0);
    hz.tnew_E = 2'd1; hz.tuse_rs_D = 2'd1;
    hz.rs_E = 5'd5;
    chk("prio_m", 0, 2, 0, 2, 0, 0);
    hz.a3_E = '0; hz.a3_M = '0; hz.rt_E = 5'd5;
    chk("prio_w", 0, 3, 0, 3, 3, 0);

    idle();
    hz.rs_D = 5'd5; hz.tuse_rs_D = '1;
    hz.a3_E = 5'd5; hz.tnew_E = 2'd2;
    hz.a3_M = 5'd5; hz.tnew_M = 2'd1;
    hz.a3_W = 5'd5; hz.rs_E = 5'd5;
    chk("unused_src", 0, 3, 0, 3, 0, 0);

    idle();
    hz.a3_M = 5'd6; hz.tnew_M = 2'd2;
    hz.rt_D = 5'd6; hz.tuse_rt_D = 2'd1;
    chk("m_hazard", 1, 0, 0, 0, 0, 0);

    idle();
    hz.md_start_E = 1'b1; hz.md_div_E = 1'b1;
    hz.md_use_D = 1'b1;
    chk("div_c0", 1, 0, 0, 0, 0, 1);
    hz.md_start_E = 1'b0; hz.md_div_E = 1'b0;
    for (int i = 1; i <= 10; i++)
      chk($sformatf("div_c%0d", i), 1, 0, 0, 0, 0, 1);
    chk("div_c11", 0, 0, 0, 0, 0, 0);

    idle();
    hz.md_start_E = 1'b1;
    chk("mul_c0", 0, 0, 0, 0, 0, 1);
    hz.md_start_E = 1'b0;
    for (int i = 1; i <= 5; i++)
      chk($sformatf("mul_c%0d", i), 0, 0, 0, 0, 0, 1);
    chk("mul_c6", 0, 0, 0, 0, 0, 0);

    hz.md_start_E = 1'b1;
    chk("cancel_c0", 0, 0, 0, 0, 0, 1);
    hz.md_start_E = 1'b0;
    chk("cancel_c1", 0, 0, 0, 0, 0, 1);
    hz.md_cancel = 1'b1;
    chk("cancel_c2", 0, 0, 0, 0, 0, 1);
    hz.md_cancel = 1'b0;
    chk("cancel_c3", 0, 0, 0, 0, 0, 0);

    hz.md_start_E = 1'b1; hz.md_cancel = 1'b1;
    chk("cancel_start", 0, 0, 0, 0, 0, 1);
    idle();
    chk("cancel_start_n", 0, 0, 0, 0, 0, 0);

    hz.md_start_E = 1'b1; hz.md_div_E = 1'b1;
    chk("rst_div_c0", 0, 0, 0, 0, 0, 1);
    idle();
    chk("rst_div_c1", 0, 0, 0, 0, 0, 1);
    chk("rst_div_c2", 0, 0, 0, 0, 0, 1);
    reset = 1'b0;
    chk("rst_div_low", 0, 0, 0, 0, 0, 1);
    reset = 1'b1;
    chk("rst_div_after", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
    end
    @(negedge clk);
    checks++;
    assert (hz2.stall_cnt === 3'b111)
    else begin
      errors++;
      $error("FAIL sat_cnt got=%h exp=%h",
             hz2.stall_cnt, 3'b111);
    end
    checks++;
    assert (hz2.stall === 1'b1)
    else begin
      errors++;
      $error("FAIL sat_stall got=%b exp=%b",
             hz2.stall, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard controller for the five-stage MIPS pipeline: it replaces per-case stall equations with a Tuse/Tnew comparison over D/E/M/W. It generates the D-stage stall and the E-stage bubble, plus forwarding selects for D and E. It also tracks a multi-cycle multiply/divide unit with an internal busy counter, and keeps a saturating stall-cycle counter for performance debug.

## Interface
- REG_AW, 5: register address width.
- T_W, 2: width of Tuse/Tnew fields.
- MUL_CYCLES, 5: busy cycles after a mult/multu start.
- DIV_CYCLES, 10: busy cycles after a div/divu start.
- CNT_W, 32: stall counter width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset.
- rs_D, rt_D  input  REG_AW each  D-stage source registers.
- tuse_rs_D, tuse_rt_D  input  T_W each  cycles until the operand is needed; all-ones means unused.
- md_use_D  input  1  D instr is mult/div/mfhi/mflo/mthi/mtlo.
- rs_E, rt_E  input  REG_AW each  E-stage source registers.
- a3_E, a3_M, a3_W  input  REG_AW each  destination register per stage; 0 means no write.
- tnew_E, tnew_M  input  T_W each  cycles until the stage's result exists.
- md_start_E  input  1  mult/div issuing in E this cycle.
- md_div_E  input  1  1 = div type, 0 = mul type; valid with md_start_E.
- md_cancel  input  1  abort the in-flight md operation (exception flush).
- stall  output  1  freeze PC and the F/D register.
- bubble_E  output  1  clear the D/E register.
- fwd_rs_D, fwd_rt_D  output  2 each  0 GRF, 1 E, 2 M, 3 W.
- fwd_rs_E, fwd_rt_E  output  2 each  0 pipe reg, 1 unused, 2 M, 3 W.
- md_busy  output  1  md unit occupied.
- stall_cnt  output  CNT_W  saturating count of stall cycles.

## Operation
- Data hazard, per source s ∈ {rs, rt}: hazard when s_D ≠ 0, tuse_s_D ≠ all-ones, and either (s_D == a3_E and tnew_E > tuse_s_D) or (s_D == a3_M and tnew_M > tuse_s_D).
- MD hazard: md_use_D and (md_busy or md_start_E).
- stall = data hazard or MD hazard.
- bubble_E = stall.
- D forwarding, priority E > M > W:
  - select E when s_D == a3_E ≠ 0 and tnew_E == 0;
  - else select M when s_D == a3_M ≠ 0 and tnew_M == 0;
  - else select W when s_D == a3_W ≠ 0;
  - else 0.
- E forwarding, priority M > W: M when s_E == a3_M ≠ 0 and tnew_M == 0; else W on a match; else 0.
- Register 0 never hazards and is never forwarded.
- MD counter md_cnt is ceil(log2(DIV_CYCLES+1)) bits. Next-state priority:
  1. reset asserted (low) → 0.
  2. md_cancel → 0.
  3. md_start_E → DIV_CYCLES if md_div_E, else MUL_CYCLES.
  4. md_cnt ≠ 0 → md_cnt − 1.
  5. otherwise hold.
- md_busy = (md_cnt ≠ 0) or md_start_E.
- md_start_E while md_cnt ≠ 0 restarts the count; upstream stalling makes this illegal, and the bench flags it as an assertion.
- stall_cnt: reset → 0; increments on each cycle with stall=1; holds at all-ones.

## Timing
- stall, bubble_E, and all fwd selects are combinational from the current-cycle inputs and md_cnt. There are no registered paths to them.
- md_busy and stall_cnt update on the clk rising edge.
- While reset is low, md_cnt = 0 and stall_cnt = 0. Combinational outputs still follow their inputs; with idle inputs (all a3 = 0, md inputs 0), stall = bubble_E = 0, all fwd = 0, md_busy = 0.
- md_start_E at edge k: md_busy = 1 combinationally in cycle k. It stays 1 in cycles k+1 … k+N (N = MUL_CYCLES or DIV_CYCLES) and falls in cycle k+N+1.
- A dependent mfhi in D stalls through cycle k+N and issues in k+N+1.
- md_cancel and md_start_E in the same cycle: cancel wins, md_cnt → 0.
- A reset pulse mid-operation clears md_cnt on that edge; md_busy is 0 in the next cycle.
- stall_cnt wrap: at all-ones with stall = 1 it stays all-ones.

## Test plan
- Load-use: a3_E = 8, tnew_E = 2, rs_D = 8, tuse_rs_D = 1 → stall = bubble_E = 1. Next cycle a3_M = 8, tnew_M = 1: stall = 0, and fwd_rs_D = 0 until W, then fwd_rs_E = 3.
- ALU to branch: a3_E = 9, tnew_E = 1, rt_D = 9, tuse_rt_D = 0 → stall = 1. Next cycle a3_M = 9, tnew_M = 0 → stall = 0, fwd_rt_D = 2.
- Register zero: a3_E = 0, tnew_E = 2, rs_D = 0 → stall = 0, fwd_rs_D = 0.
- Forwarding priority: rs_D = 5 with a3_E = a3_M = a3_W = 5, both tnew = 0 → fwd_rs_D = 1. With tnew_E = 1 and tuse_rs_D = 1 → stall = 0, fwd_rs_D = 2.
- Divide then mflo: md_start_E = 1, md_div_E = 1 at cycle 0; md_use_D = 1 from cycle 0 → stall = 1 for cycles 0–10, 0 at cycle 11, stall_cnt = 11.
- Cancel and reset: mult started, md_cancel at cycle 2 → md_busy = 0 at cycle 3. Separately, reset low mid-divide → md_cnt = 0 and stall_cnt = 0 the next cycle.
